// File: rtl/avg_filter_pkg.sv
// Shared types and helpers for the multi-channel boxcar averaging filter.
// Holds the controller state encoding and the width/slice arithmetic used by every channel.
package avg_filter_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_FETCH,
    ST_ACCUM,
    ST_HOLD
  } state_t;

  // A sum of 2^log2_depth signed samples needs log2_depth extra bits to be exact.
  function automatic int acc_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  function automatic int chan_lsb(input int chan, input int data_w);
    return chan * data_w;
  endfunction

endpackage

// File: rtl/avg_delay_ram.sv
// Simple dual-port synchronous RAM used as one channel's circular delay line.
// Registered read port with a one-cycle latency; write and read ports are independent.
module avg_delay_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 6
) (
  input  logic              CLOCK_50,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // NOTE: the storage array has no reset; the controller zeroes it by walking every address
  // after reset, which keeps this mappable onto block RAM.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/boxcar_avg_filter.sv
// Multi-channel moving-average filter with valid/ready streaming, bypass and flush.
// Each accepted sample set walks IDLE -> FETCH -> ACCUM -> HOLD; CLEAR zeroes the window.
module boxcar_avg_filter
  import avg_filter_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 6,
  parameter int CHANNELS   = 2
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  input  logic                         bypass,
  input  logic                         flush,
  output logic                         primed
);

  localparam int N     = 1 << LOG2_DEPTH;
  localparam int ACC_W = acc_width(DATA_W, LOG2_DEPTH);
  localparam int CNT_W = LOG2_DEPTH + 1;

  state_t                       state, state_next;
  logic [LOG2_DEPTH-1:0]        wr_ptr;
  logic [LOG2_DEPTH-1:0]        clr_cnt;
  logic [CNT_W-1:0]             fill_cnt;
  logic [CHANNELS*DATA_W-1:0]   x_hold;
  logic                         bypass_hold;
  logic                         accept;
  logic                         clear_done;
  logic                         ram_we;
  logic [LOG2_DEPTH-1:0]        ram_waddr;

  // Flush wins over a same-cycle input handshake, so it masks in_ready directly.
  assign in_ready   = (state == ST_IDLE) && !flush;
  assign accept     = in_ready && in_valid;
  assign out_valid  = (state == ST_HOLD);
  assign clear_done = (state == ST_CLEAR) && (clr_cnt == LOG2_DEPTH'(N - 1));
  assign primed     = (fill_cnt == CNT_W'(N));

  assign ram_we    = (state == ST_CLEAR) || (state == ST_FETCH);
  assign ram_waddr = (state == ST_CLEAR) ? clr_cnt : wr_ptr;

  // NOTE: every sequential block uses non-blocking assignments so all registers update
  // from the same pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_CLEAR: if (clear_done) state_next = ST_IDLE;
      ST_IDLE:  if (in_valid)   state_next = ST_FETCH;
      ST_FETCH:                 state_next = ST_ACCUM;
      ST_ACCUM:                 state_next = ST_HOLD;
      ST_HOLD:  if (out_ready)  state_next = ST_IDLE;
      default:                  state_next = ST_CLEAR;
    endcase
    if (flush) state_next = ST_CLEAR;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || flush)          clr_cnt <= '0;
    else if (state == ST_CLEAR)  clr_cnt <= clr_cnt + LOG2_DEPTH'(1);
  end

  // wr_ptr wraps naturally at N because its width is exactly LOG2_DEPTH.
  always_ff @(posedge CLOCK_50) begin
    if (reset || state == ST_CLEAR) wr_ptr <= '0;
    else if (state == ST_FETCH)     wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || flush || state == ST_CLEAR)  fill_cnt <= '0;
    else if (accept && !primed)               fill_cnt <= fill_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x_hold      <= '0;
      bypass_hold <= 1'b0;
    end else if (accept) begin
      x_hold      <= in_data;
      bypass_hold <= bypass;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    localparam int LSB = chan_lsb(k, DATA_W);

    logic        [DATA_W-1:0] ram_q;
    logic        [DATA_W-1:0] ram_wdata;
    logic signed [DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0] q_s;
    logic signed [ACC_W-1:0]  acc;
    logic        [DATA_W-1:0] out_reg;

    assign x_s       = x_hold[LSB +: DATA_W];
    assign q_s       = ram_q;
    assign ram_wdata = (state == ST_CLEAR) ? '0 : x_hold[LSB +: DATA_W];

    avg_delay_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (LOG2_DEPTH)
    ) u_ram (
      .CLOCK_50 (CLOCK_50),
      .wr_en    (ram_we),
      .wr_addr  (ram_waddr),
      .wr_data  (ram_wdata),
      .rd_en    (accept),
      .rd_addr  (wr_ptr),
      .rd_data  (ram_q)
    );

    // ram_q holds the sample leaving the window, so the sum stays exact without re-adding.
    always_ff @(posedge CLOCK_50) begin
      if (reset || state == ST_CLEAR) acc <= '0;
      else if (state == ST_FETCH)     acc <= acc + ACC_W'(x_s) - ACC_W'(q_s);
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset)                               out_reg <= '0;
      else if (state == ST_ACCUM && !flush)    out_reg <= bypass_hold ? x_hold[LSB +: DATA_W]
                                                                      : DATA_W'(acc >>> LOG2_DEPTH);
    end

    assign out_data[LSB +: DATA_W] = out_reg;
  end

endmodule

// File: tb/tb_boxcar_avg_filter.sv
// Self-checking bench for boxcar_avg_filter (DATA_W=24, N=4, two channels).
// Expected outputs come from a window-array model with floor division.
module tb_boxcar_avg_filter;

  localparam int DATA_W = 24;
  localparam int L2     = 2;
  localparam int N      = 1 << L2;
  localparam int CH     = 2;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CH*DATA_W-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [CH*DATA_W-1:0] out_data;
  logic                 bypass = 1'b0;
  logic                 flush = 1'b0;
  logic                 primed;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference window: plain arrays of past samples, oldest overwritten first.
  int win [CH][N];
  int win_pos;
  int win_fill;

  boxcar_avg_filter #(.DATA_W(DATA_W), .LOG2_DEPTH(L2), .CHANNELS(CH)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .bypass    (bypass),
    .flush     (flush),
    .primed    (primed)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input longint s);
    if (s >= 0) return int'(s / N);
    return int'(-((-s + N - 1) / N));
  endfunction

  function automatic int sx24(input logic [23:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd24();
    logic [23:0] r;
    r = 24'($urandom);
    return sx24(r);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < N; i++) win[c][i] = 0;
    win_pos  = 0;
    win_fill = 0;
  endtask

  task automatic model_accept(input int a, input int b, input bit byp,
                              output int e0, output int e1);
    longint s0, s1;
    win[0][win_pos] = a;
    win[1][win_pos] = b;
    win_pos  = (win_pos + 1) % N;
    win_fill = (win_fill < N) ? win_fill + 1 : N;
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < N; i++) begin
      s0 += win[0][i];
      s1 += win[1][i];
    end
    e0 = byp ? a : floor_div(s0);
    e1 = byp ? b : floor_div(s1);
  endtask

  // Counts CLEAR cycles (in_ready low) from the current negedge; expects exactly N.
  task automatic wait_clear(input string tag);
    int n;
    bit noisy;
    n = 0;
    noisy = 0;
    while (!in_ready && n < 20) begin
      if (out_valid || primed) noisy = 1;
      n++;
      @(negedge CLOCK_50);
    end
    check({tag, "_len"}, n, N);
    check({tag, "_quiet"}, noisy, 0);
    model_clear();
  endtask

  // Presents one set, waits for acceptance and for out_valid; checks latency.
  task automatic issue(input int a, input int b, input bit byp, output int e0, output int e1,
                       output bit ok);
    int n;
    logic [23:0] a24, b24;
    a24 = a[23:0];
    b24 = b[23:0];
    ok = 0;
    in_data  = {b24, a24};
    bypass   = byp;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_accept(a, b, byp, e0, e1);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    bypass   = ~byp;
    in_data  = {24'($urandom), 24'($urandom)};
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("latency", n, 3);
    ok = out_valid;
  endtask

  task automatic send(input int a, input int b, input bit byp, input int hold);
    int e0, e1;
    bit ok, stable;
    logic [CH*DATA_W-1:0] snap;
    out_ready = (hold == 0);
    issue(a, b, byp, e0, e1, ok);
    if (!ok) begin
      out_ready = 1'b1;
      return;
    end
    check("ch0", sx24(out_data[23:0]), e0);
    check("ch1", sx24(out_data[47:24]), e1);
    check("primed", primed, win_fill == N);
    if (hold > 0) begin
      snap = out_data;
      stable = 1;
      repeat (hold) begin
        @(negedge CLOCK_50);
        if (out_data !== snap || in_ready || !out_valid) stable = 0;
      end
      check("backpressure_hold", stable, 1);
      out_ready = 1'b1;
    end
    @(negedge CLOCK_50);
    check("ready_after_xfer", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge CLOCK_50);
    flush = 1'b0;
    wait_clear("flush_clear");
  endtask

  initial begin
    int e0, e1;
    bit ok;
    model_clear();

    // Reset held for three cycles, then CLEAR must take exactly N cycles.
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_primed", primed, 0);
    reset = 1'b0;
    wait_clear("reset_clear");

    // Step response ramps up then settles.
    for (int i = 0; i < 6; i++) send(400, -400, 1'b0, 0);

    // Floor toward -inf and extreme values.
    do_flush();
    send(-1, -1, 1'b0, 0);
    for (int i = 0; i < 4; i++) send(0, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) send(24'h7FFFFF, 24'h7FFFFF, 1'b0, 0);
    for (int i = 0; i < 4; i++) send(-8388608, -8388608, 1'b0, 0);

    // Backpressure in HOLD.
    send(123, -77, 1'b0, 10);

    // Bypass on a primed window of 400s.
    do_flush();
    for (int i = 0; i < 4; i++) send(400, 400, 1'b0, 0);
    send(1000, -1000, 1'b1, 0);
    send(400, 400, 1'b0, 0);

    // Flush while a result waits in HOLD.
    out_ready = 1'b0;
    issue(555, 555, 1'b0, e0, e1, ok);
    flush = 1'b1;
    @(negedge CLOCK_50);
    check("flush_hold_valid", out_valid, 0);
    check("flush_hold_ready", in_ready, 0);
    check("flush_hold_primed", primed, 0);
    flush = 1'b0;
    out_ready = 1'b1;
    wait_clear("flush_hold_clear");
    send(800, 800, 1'b0, 0);

    // Randomised traffic with occasional bypass and backpressure.
    for (int i = 0; i < 30; i++) begin
      int a, b;
      a = (i % 7 == 3) ? 24'h7FFFFF : rnd24();
      b = (i % 5 == 2) ? -8388608 : rnd24();
      send(a, b, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    // Reset in the middle of a transfer zeroes the output and restarts CLEAR.
    out_ready = 1'b0;
    issue(321, -321, 1'b0, e0, e1, ok);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    wait_clear("midrst_clear");
    send(-9, 9, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
